// File: rtl/neuron_layer_sequencer_pkg.sv
// Shared constants, state encoding and bias sign-extension for the layer sequencer.
// NUM_INPUTS must be a whole multiple of LANES; BATCHES truncates otherwise.
package neuron_layer_sequencer_pkg;

   localparam int NUM_INPUTS   = 784;
   localparam int LANES        = 16;
   localparam int NUM_NEURONS  = 10;
   localparam int WEIGHT_WIDTH = 19;
   localparam int OUTPUT_WIDTH = 26;

   localparam int BATCHES = NUM_INPUTS / LANES;
   localparam int PIX_AW  = $clog2(BATCHES);
   localparam int WGT_AW  = $clog2(NUM_NEURONS * BATCHES);
   localparam int N_AW    = $clog2(NUM_NEURONS);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_DRAIN,
      ST_WRITE,
      ST_DONE
   } seq_state_t;

   // 1.18 bias aligned to the 8.18 accumulator by replicating its sign bit
   function automatic logic [OUTPUT_WIDTH-1:0] sext_bias(input logic [WEIGHT_WIDTH-1:0] b);
      return {{(OUTPUT_WIDTH-WEIGHT_WIDTH){b[WEIGHT_WIDTH-1]}}, b};
   endfunction

endpackage

// File: rtl/neuron_layer_sequencer_if.sv
// Control, memory-address and MAC-engine signals of the layer sequencer.
// master = the sequencer, slave = inference control, memories and MAC engine.
interface neuron_layer_sequencer_if;
   import neuron_layer_sequencer_pkg::*;

   logic                    start;
   logic                    abort;
   logic                    hold;
   logic                    busy;
   logic                    done;
   logic [PIX_AW-1:0]       pix_addr;
   logic [WGT_AW-1:0]       wgt_addr;
   logic [N_AW-1:0]         bias_addr;
   logic [WEIGHT_WIDTH-1:0] bias_data;
   logic                    mac_en;
   logic                    mac_first;
   logic                    mac_last;
   logic                    mac_flush;
   logic                    acc_valid;
   logic [OUTPUT_WIDTH-1:0] acc_data;
   logic                    res_we;
   logic [N_AW-1:0]         res_addr;
   logic [OUTPUT_WIDTH-1:0] res_data;

   modport master (
      input  start, abort, hold, bias_data, acc_valid, acc_data,
      output busy, done, pix_addr, wgt_addr, bias_addr,
             mac_en, mac_first, mac_last, mac_flush,
             res_we, res_addr, res_data
   );

   modport slave (
      output start, abort, hold, bias_data, acc_valid, acc_data,
      input  busy, done, pix_addr, wgt_addr, bias_addr,
             mac_en, mac_first, mac_last, mac_flush,
             res_we, res_addr, res_data
   );

endinterface

// File: rtl/neuron_layer_sequencer_batch_address_gen.sv
// Batch/neuron counters and registered beat addressing for the shared MAC engine.
// clear and advance may coincide: the beat is then issued from batch 0 of neuron 0.
module neuron_layer_sequencer_batch_address_gen
   import neuron_layer_sequencer_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              advance,
   input  logic              next_neuron,
   output logic [PIX_AW-1:0] pix_addr,
   output logic [WGT_AW-1:0] wgt_addr,
   output logic              mac_first,
   output logic              mac_last,
   output logic [N_AW-1:0]   neuron,
   output logic              batch_last,
   output logic              neuron_last
);

   localparam logic [PIX_AW-1:0] LAST_BATCH = PIX_AW'(BATCHES - 1);

   logic [PIX_AW-1:0] batch;
   logic [PIX_AW-1:0] batch_cur;
   logic [N_AW-1:0]   neuron_cur;
   logic [WGT_AW-1:0] wgt_base;
   logic [WGT_AW-1:0] wgt_base_cur;

   // wgt_base tracks neuron*BATCHES incrementally so no multiplier is needed
   always_comb begin
      batch_cur    = clear ? '0 : batch;
      neuron_cur   = neuron;
      wgt_base_cur = wgt_base;
      if (clear) begin
         neuron_cur   = '0;
         wgt_base_cur = '0;
      end else if (next_neuron) begin
         neuron_cur   = neuron + 1'b1;
         wgt_base_cur = wgt_base + WGT_AW'(BATCHES);
      end
   end

   assign batch_last  = (batch == LAST_BATCH);
   assign neuron_last = (neuron == N_AW'(NUM_NEURONS - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         batch     <= '0;
         neuron    <= '0;
         wgt_base  <= '0;
         pix_addr  <= '0;
         wgt_addr  <= '0;
         mac_first <= 1'b0;
         mac_last  <= 1'b0;
      end else begin
         neuron    <= neuron_cur;
         wgt_base  <= wgt_base_cur;
         mac_first <= 1'b0;
         mac_last  <= 1'b0;
         if (advance) begin
            pix_addr  <= batch_cur;
            wgt_addr  <= wgt_base_cur + WGT_AW'(batch_cur);
            mac_first <= (batch_cur == '0);
            mac_last  <= (batch_cur == LAST_BATCH);
            batch     <= (batch_cur == LAST_BATCH) ? '0 : batch_cur + 1'b1;
         end else begin
            batch <= batch_cur;
            if (clear) begin
               pix_addr <= '0;
               wgt_addr <= '0;
            end
         end
      end
   end

endmodule

// File: rtl/neuron_layer_sequencer.sv
// Sequences one pipelined MAC engine across every neuron of a fully connected layer.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | waiting for start; all strobes low
//   ISSUE    | streaming batches to the MAC engine, stalled by hold
//   DRAIN    | all beats issued, waiting for acc_valid
//   WRITE    | result strobe for this neuron; next neuron's beat 0 issues
//   DONE     | done pulse, busy still high
module neuron_layer_sequencer
   import neuron_layer_sequencer_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   neuron_layer_sequencer_if.master bus
);

   seq_state_t state;

   logic advance;
   logic clear;
   logic next_neuron;
   logic batch_last;
   logic neuron_last;

   logic [N_AW-1:0]         neuron;
   logic [PIX_AW-1:0]       pix_addr;
   logic [WGT_AW-1:0]       wgt_addr;
   logic                    mac_first;
   logic                    mac_last;
   logic                    busy_q;
   logic                    done_q;
   logic                    mac_en_q;
   logic                    mac_flush_q;
   logic                    res_we_q;
   logic [N_AW-1:0]         res_addr_q;
   logic [OUTPUT_WIDTH-1:0] res_data_q;

   // Beat 0 goes out on the edge that enters ISSUE, so neurons run back to back
   always_comb begin
      advance     = 1'b0;
      clear       = 1'b0;
      next_neuron = 1'b0;
      case (state)
         ST_IDLE: begin
            clear   = bus.start;
            advance = bus.start & ~bus.hold;
         end
         ST_ISSUE: begin
            clear   = bus.abort;
            advance = ~bus.abort & ~bus.hold;
         end
         ST_WRITE: begin
            clear       = bus.abort;
            next_neuron = ~bus.abort & ~neuron_last;
            advance     = next_neuron & ~bus.hold;
         end
         default: clear = bus.abort;
      endcase
   end

   neuron_layer_sequencer_batch_address_gen u_addr_gen (
      .clk         (clk),
      .rst         (rst),
      .clear       (clear),
      .advance     (advance),
      .next_neuron (next_neuron),
      .pix_addr    (pix_addr),
      .wgt_addr    (wgt_addr),
      .mac_first   (mac_first),
      .mac_last    (mac_last),
      .neuron      (neuron),
      .batch_last  (batch_last),
      .neuron_last (neuron_last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         mac_en_q    <= 1'b0;
         mac_flush_q <= 1'b0;
         res_we_q    <= 1'b0;
         res_addr_q  <= '0;
         res_data_q  <= '0;
      end else begin
         done_q      <= 1'b0;
         mac_flush_q <= 1'b0;
         res_we_q    <= 1'b0;
         mac_en_q    <= advance;
         if (state != ST_IDLE && bus.abort) begin
            state       <= ST_IDLE;
            busy_q      <= 1'b0;
            mac_flush_q <= 1'b1;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (bus.start) begin
                     state  <= ST_ISSUE;
                     busy_q <= 1'b1;
                  end
               end
               ST_ISSUE: begin
                  if (advance && batch_last) state <= ST_DRAIN;
               end
               ST_DRAIN: begin
                  if (bus.acc_valid) begin
                     state      <= ST_WRITE;
                     res_we_q   <= 1'b1;
                     res_addr_q <= neuron;
                     res_data_q <= bus.acc_data + sext_bias(bus.bias_data);
                  end
               end
               ST_WRITE: begin
                  if (neuron_last) begin
                     state  <= ST_DONE;
                     done_q <= 1'b1;
                  end else begin
                     state <= ST_ISSUE;
                  end
               end
               ST_DONE: begin
                  state  <= ST_IDLE;
                  busy_q <= 1'b0;
               end
               default: begin
                  state  <= ST_IDLE;
                  busy_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.pix_addr  = pix_addr;
   assign bus.wgt_addr  = wgt_addr;
   assign bus.bias_addr = neuron;
   assign bus.mac_en    = mac_en_q;
   assign bus.mac_first = mac_first;
   assign bus.mac_last  = mac_last;
   assign bus.mac_flush = mac_flush_q;
   assign bus.res_we    = res_we_q;
   assign bus.res_addr  = res_addr_q;
   assign bus.res_data  = res_data_q;

endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// Self-checking bench: latency-3 MAC engine model, beat-order monitor and result scoreboard.
module tb_neuron_layer_sequencer;
   import neuron_layer_sequencer_pkg::*;

   localparam int MAC_LAT = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   neuron_layer_sequencer_if ifc ();

   neuron_layer_sequencer dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   typedef struct {
      logic [OUTPUT_WIDTH-1:0] acc;
      logic [WEIGHT_WIDTH-1:0] bias;
      logic [OUTPUT_WIDTH-1:0] exp;
   } vec_t;

   typedef struct {
      logic [N_AW-1:0]         a;
      logic [OUTPUT_WIDTH-1:0] d;
   } wr_t;

   vec_t tab [NUM_NEURONS];

   logic [WEIGHT_WIDTH-1:0] bias_mem [16];
   logic [OUTPUT_WIDTH-1:0] acc_val  [16];
   logic [OUTPUT_WIDTH-1:0] exp_res  [NUM_NEURONS];

   assign ifc.bias_data = bias_mem[ifc.bias_addr];

   int n_chk = 0;
   int n_ok  = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_ok++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   function automatic logic [OUTPUT_WIDTH-1:0] model_res(input logic [OUTPUT_WIDTH-1:0] acc,
                                                         input logic [WEIGHT_WIDTH-1:0] b);
      logic signed [OUTPUT_WIDTH-1:0] a_s;
      logic signed [OUTPUT_WIDTH-1:0] b_s;
      a_s = $signed(acc);
      b_s = $signed(b);
      return a_s + b_s;
   endfunction

   // MAC engine: the final sum appears MAC_LAT cycles after mac_last
   logic            pipe_v [MAC_LAT];
   logic [3:0]      pipe_n [MAC_LAT];
   logic            force_av = 1'b0;

   always @(negedge clk) begin
      if (rst || ifc.mac_flush) begin
         for (int i = 0; i < MAC_LAT; i++) pipe_v[i] = 1'b0;
         ifc.acc_valid = force_av;
         ifc.acc_data  = 26'h155AAAA;
      end else begin
         ifc.acc_valid = pipe_v[MAC_LAT-1] | force_av;
         ifc.acc_data  = pipe_v[MAC_LAT-1] ? acc_val[pipe_n[MAC_LAT-1]] : 26'h155AAAA;
         for (int i = MAC_LAT-1; i > 0; i--) begin
            pipe_v[i] = pipe_v[i-1];
            pipe_n[i] = pipe_n[i-1];
         end
         pipe_v[0] = ifc.mac_en & ifc.mac_last;
         pipe_n[0] = 4'(ifc.wgt_addr / BATCHES);
      end
   end

   // Monitor: beats must enumerate 0..NUM_NEURONS*BATCHES-1 in order
   int  pass_id   = 0;
   int  mon_pass  = 0;
   int  exp_beat  = 0;
   int  beat_err  = 0;
   int  beat_cnt  = 0;
   int  done_cnt  = 0;
   wr_t wr_q [$];

   always @(negedge clk) begin
      if (pass_id != mon_pass) begin
         mon_pass = pass_id;
         exp_beat = 0;
         beat_err = 0;
         beat_cnt = 0;
         done_cnt = 0;
         wr_q.delete();
      end
      if (ifc.mac_en) begin
         if (ifc.wgt_addr != WGT_AW'(exp_beat) ||
             ifc.pix_addr != PIX_AW'(exp_beat % BATCHES) ||
             ifc.mac_first != ((exp_beat % BATCHES) == 0) ||
             ifc.mac_last != ((exp_beat % BATCHES) == BATCHES-1))
            beat_err++;
         exp_beat++;
         beat_cnt++;
      end
      if (ifc.res_we) wr_q.push_back('{ifc.res_addr, ifc.res_data});
      if (ifc.done) done_cnt++;
   end

   task automatic randomize_layer();
      for (int n = 0; n < NUM_NEURONS; n++) begin
         acc_val[n]  = OUTPUT_WIDTH'($urandom);
         bias_mem[n] = WEIGHT_WIDTH'($urandom);
         exp_res[n]  = model_res(acc_val[n], bias_mem[n]);
      end
   endtask

   task automatic start_pass();
      pass_id++;
      ifc.start = 1'b1;
      tick();
      ifc.start = 1'b0;
   endtask

   task automatic wait_beat(input int addr, input int budget, input string nm);
      int n = 0;
      while (!(ifc.mac_en && ifc.wgt_addr == WGT_AW'(addr)) && n < budget) begin
         tick();
         n++;
      end
      check(nm, 64'(n < budget), 64'd1);
   endtask

   task automatic run_to_done(input string nm, input bit rnd_hold);
      int n = 0;
      while (done_cnt == 0 && n < 4000) begin
         if (rnd_hold) ifc.hold = ($urandom_range(0, 3) == 0);
         tick();
         n++;
      end
      ifc.hold = 1'b0;
      check({nm, "_done_seen"}, 64'(done_cnt), 64'd1);
      tick();
      check({nm, "_busy_after_done"}, 64'(ifc.busy), 64'd0);
      repeat (5) tick();
      check({nm, "_single_done"}, 64'(done_cnt), 64'd1);
      check({nm, "_beat_order"}, 64'(beat_err), 64'd0);
      check({nm, "_beat_count"}, 64'(beat_cnt), 64'(NUM_NEURONS * BATCHES));
   endtask

   task automatic check_writes(input string nm, input int count);
      check({nm, "_wr_count"}, 64'(wr_q.size()), 64'(count));
      for (int i = 0; i < count && i < wr_q.size(); i++) begin
         check($sformatf("%s_res_addr%0d", nm, i), 64'(wr_q[i].a), 64'(i));
         check($sformatf("%s_res_data%0d", nm, i), 64'(wr_q[i].d), 64'(exp_res[i]));
      end
   endtask

   initial begin
      int gap_err;
      int issue_err;

      tab[0] = '{26'h0000100, 19'h7FFFF, 26'h00000FF};
      tab[1] = '{26'h3FFFFFF, 19'h00001, 26'h0000000};
      tab[2] = '{26'h0000000, 19'h3FFFF, 26'h003FFFF};
      tab[3] = '{26'h0000000, 19'h40000, 26'h3FC0000};
      tab[4] = '{26'h1FFFFFF, 19'h00001, 26'h2000000};
      tab[5] = '{26'h2000000, 19'h7FFFF, 26'h1FFFFFF};
      tab[6] = '{26'h0123456, 19'h00000, 26'h0123456};
      tab[7] = '{26'h1000000, 19'h40000, 26'h0FC0000};
      tab[8] = '{26'h3FFFF00, 19'h00100, 26'h0000000};
      tab[9] = '{26'h0000005, 19'h7FFFB, 26'h0000000};
      for (int n = 0; n < 16; n++) begin
         bias_mem[n] = '0;
         acc_val[n]  = '0;
      end

      ifc.start = 1'b0;
      ifc.abort = 1'b0;
      ifc.hold  = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      check("reset_outputs",
            64'({ifc.busy, ifc.done, ifc.mac_en, ifc.mac_first, ifc.mac_last, ifc.mac_flush,
                 ifc.res_we, ifc.res_addr, ifc.res_data, ifc.pix_addr, ifc.wgt_addr, ifc.bias_addr}),
            64'd0);
      rst = 1'b0;
      tick();

      // Pass A: bias table, neuron 0 timing checked cycle by cycle
      for (int n = 0; n < NUM_NEURONS; n++) begin
         acc_val[n]  = tab[n].acc;
         bias_mem[n] = tab[n].bias;
         exp_res[n]  = tab[n].exp;
      end
      start_pass();
      check("a_busy_after_start", 64'(ifc.busy), 64'd1);
      issue_err = 0;
      for (int i = 0; i < BATCHES; i++) begin
         if (!ifc.mac_en || ifc.wgt_addr != WGT_AW'(i) || ifc.pix_addr != PIX_AW'(i) ||
             ifc.mac_first != (i == 0) || ifc.mac_last != (i == BATCHES-1))
            issue_err++;
         tick();
      end
      check("a_n0_issue_cycles", 64'(issue_err), 64'd0);
      check("a_n0_mac_en_after_last", 64'(ifc.mac_en), 64'd0);
      run_to_done("a", 1'b0);
      check_writes("a", NUM_NEURONS);

      // Pass B: hold stall in neuron 2, stray start and acc_valid during ISSUE
      randomize_layer();
      start_pass();
      wait_beat(2*BATCHES + 9, 400, "b_reach_n2_b9");
      ifc.hold = 1'b1;
      gap_err = 0;
      repeat (5) begin
         tick();
         if (ifc.mac_en) gap_err++;
      end
      ifc.hold = 1'b0;
      check("b_hold_no_issue", 64'(gap_err), 64'd0);
      tick();
      check("b_resume_beat", 64'({ifc.mac_en, ifc.pix_addr, ifc.wgt_addr}),
            64'({1'b1, PIX_AW'(10), WGT_AW'(2*BATCHES + 10)}));
      wait_beat(3*BATCHES + 5, 200, "b_reach_n3_b5");
      ifc.start = 1'b1;
      tick();
      ifc.start = 1'b0;
      repeat (3) tick();
      force_av = 1'b1;
      tick();
      force_av = 1'b0;
      run_to_done("b", 1'b0);
      check_writes("b", NUM_NEURONS);

      // Pass C: random data with random memory stalls
      randomize_layer();
      start_pass();
      run_to_done("c", 1'b1);
      check_writes("c", NUM_NEURONS);

      // Pass D: abort while draining neuron 4
      randomize_layer();
      start_pass();
      wait_beat(4*BATCHES + BATCHES-1, 600, "d_reach_n4_last");
      tick();
      ifc.abort = 1'b1;
      tick();
      ifc.abort = 1'b0;
      check("d_flush_pulse", 64'(ifc.mac_flush), 64'd1);
      check("d_busy_low", 64'(ifc.busy), 64'd0);
      tick();
      check("d_flush_single", 64'(ifc.mac_flush), 64'd0);
      repeat (10) tick();
      check("d_no_done", 64'(done_cnt), 64'd0);
      check_writes("d", 4);

      // Pass E: restart after abort
      start_pass();
      check("e_restart_beat", 64'({ifc.mac_en, ifc.mac_first, ifc.wgt_addr}),
            64'({1'b1, 1'b1, WGT_AW'(0)}));
      run_to_done("e", 1'b0);
      check_writes("e", NUM_NEURONS);

      // Pass F: asynchronous reset between edges in the middle of ISSUE
      randomize_layer();
      start_pass();
      wait_beat(2*BATCHES + 20, 400, "f_reach_n2_b20");
      #2;
      rst = 1'b1;
      #1;
      check("f_async_reset_outputs",
            64'({ifc.busy, ifc.mac_en, ifc.mac_first, ifc.pix_addr, ifc.wgt_addr,
                 ifc.bias_addr, ifc.res_we, ifc.done}),
            64'd0);
      tick();
      rst = 1'b0;
      tick();
      tick();
      check("f_idle_after_release", 64'({ifc.busy, ifc.mac_en, ifc.mac_flush}), 64'd0);

      $display("%0d/%0d checks passed", n_ok, n_chk);
      $finish;
   end

endmodule

// File: doc/neuron_layer_sequencer.md
Name: neuron_layer_sequencer

Overview:
- Sequences one shared, pipelined multiply-accumulate engine across all neurons of a fully connected layer.
- For each neuron it streams NUM_INPUTS/LANES pixel/weight batches into the engine and waits for the accumulated sum.
- It then adds the neuron's bias and writes the result to the layer output buffer.
- It sits between the top-level inference control (start/done) and the MAC engine plus its pixel, weight and bias memories.

Parameters:
- NUM_INPUTS, 784, pixels per neuron; must be a multiple of LANES.
- LANES, 16, products consumed by the MAC engine per issued beat.
- NUM_NEURONS, 10, neurons in the layer.
- WEIGHT_WIDTH, 19, bias width (signed, 1.18 fixed point).
- OUTPUT_WIDTH, 26, accumulator/result width (signed, 8.18 fixed point).
- Derived constants: BATCHES = NUM_INPUTS/LANES (49); PIX_AW = clog2(BATCHES); WGT_AW = clog2(NUM_NEURONS*BATCHES); N_AW = clog2(NUM_NEURONS).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a layer pass; sampled only in IDLE.
- abort  in  1  synchronous abort of the current pass.
- hold  in  1  memory not ready; suppresses issue in ISSUE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the last neuron has been written.
- pix_addr  out  PIX_AW  batch index into the pixel memory.
- wgt_addr  out  WGT_AW  neuron*BATCHES + batch.
- bias_addr  out  N_AW  current neuron index.
- bias_data  in  WEIGHT_WIDTH  signed bias; valid while bias_addr is stable.
- mac_en  out  1  issue one beat to the MAC engine.
- mac_first  out  1  with mac_en: clear the accumulator before this beat.
- mac_last  out  1  with mac_en: final beat of this neuron.
- mac_flush  out  1  one-cycle pulse: discard in-flight beats.
- acc_valid  in  1  MAC engine final sum valid (follows mac_last by the engine latency).
- acc_data  in  OUTPUT_WIDTH  signed final sum.
- res_we  out  1  result write strobe.
- res_addr  out  N_AW  neuron index of the result.
- res_data  out  OUTPUT_WIDTH  acc_data + sign-extended bias.

Behaviour:
- Reset (asynchronous): state=IDLE; neuron=0; batch=0; all outputs 0.
- All outputs are registered.
- States: IDLE, ISSUE, DRAIN, WRITE, DONE.
- IDLE:
  - start=1 -> clear neuron and batch, go to ISSUE.
  - start is ignored in every other state; it is not queued.
- ISSUE, each cycle with hold=0:
  - mac_en=1; pix_addr=batch; wgt_addr=neuron*BATCHES+batch.
  - mac_first=(batch==0); mac_last=(batch==BATCHES-1).
  - batch increments. After the last beat, batch returns to 0 and the state goes to DRAIN.
- ISSUE with hold=1: mac_en=0 and the counters freeze. Beat order is never skipped or duplicated.
- DRAIN: mac_en=0; wait for acc_valid. acc_valid seen in any state other than DRAIN is ignored.
- acc_valid in DRAIN -> WRITE, with the result captured:
  - res_data = acc_data + {7 copies of bias_data MSB, bias_data}.
  - The add wraps modulo 2^OUTPUT_WIDTH; there is no saturation.
- WRITE (exactly one cycle): res_we=1; res_addr=neuron.
  - If neuron==NUM_NEURONS-1 -> DONE.
  - Otherwise neuron increments -> ISSUE.
- DONE: done=1 for one cycle, then IDLE. busy stays high in DONE and drops in IDLE.
- Minimum time per neuron: BATCHES issue cycles + engine latency + 1 write cycle. No gap is inserted between neurons.
- abort=1 in any non-IDLE state:
  - Next cycle: IDLE, counters cleared, mac_flush=1 for one cycle.
  - No res_we and no done for the aborted pass.
  - abort has priority over every other transition, including acc_valid and the WRITE-cycle transition. abort in IDLE has no effect.
- Reset mid-pass has the same effect as abort, except no mac_flush is generated.
- The bias_addr output is combinationally equal to the registered neuron counter, so bias_data is stable for the whole neuron.

Decomposition:
- Shared package: derived constants BATCHES, PIX_AW, WGT_AW, N_AW; the state enum; the sign-extend-bias function. The Neuron datapath reuses these.
- One natural sub-module: batch_address_gen, which holds the batch/neuron counters and the address, mac_first and mac_last generation, with an advance/clear interface. The FSM, bias add and result register stay in the top.

Test Plan:
- Basic pass with MAC latency 3 and hold=0:
  - start pulsed at cycle 0 -> mac_en high cycles 1..49.
  - mac_first at cycle 1 only; mac_last at cycle 49; wgt_addr 0..48.
  - res_we at neuron 0 with res_addr=0. For a full pass: 10 writes with wgt_addr spanning 0..489, then a single done pulse.
- Bias sign extension:
  - acc_data=26'h0000100, bias_data=19'h7FFFF (-1 LSB) -> res_data=26'h00000FF.
  - acc_data=26'h3FFFFFF, bias=19'h00001 -> res_data=0 (wrap).
- Hold stall: hold=1 during batches 10..14 of neuron 2 -> no mac_en for 5 cycles; resumes with pix_addr=10; each address 0..48 issued exactly once.
- Abort: abort while in DRAIN of neuron 4 -> mac_flush pulse, busy low next cycle, no res_we for neuron 4, no done. A following start restarts at wgt_addr=0.
- Start and acc_valid edge cases:
  - start pulsed during ISSUE -> ignored; pass completes normally.
  - acc_valid pulsed during ISSUE -> ignored; no spurious write.
- Asynchronous reset asserted mid-ISSUE, between clock edges -> all outputs 0 immediately; state IDLE after release.
